delay_tap_scanner: RTL
======================

// Module: delay_tap_scanner
// PURPOSE
//  Upstream sweep controller for the RX delay chain. Steps the 8-bit tap select 0..NUM_TAPS-1.
//  At each tap it waits for settling, then counts mismatches between the delayed sample and a
//  reference sample over a fixed window. Reports per-tap error counts and the centre of the
//  widest zero-error tap run, which the PCIe scan logic uses as the RX delay setting.
// PARAMETERS
//  TAP_W      8     width of delay_line_rx
//  NUM_TAPS   256   taps swept; NUM_TAPS <= 2**TAP_W
//  SETTLE_CYC 16    cycles held in SETTLE per tap (>=3; covers synchroniser flush)
//  WINDOW_CYC 1024  compare cycles per tap
//  CNT_W      16    error counter width, saturating
// PORTS
//  clk            in   1        system clock
//  rst_n          in   1        async active-low reset
//  start          in   1        scan request, sampled in IDLE only
//  dly_in         in   1        delayed sample from delay chain output (async to clk)
//  ref_in         in   1        reference sample (async to clk)
//  delay_line_rx  out  TAP_W    tap select driven into the delay chain
//  busy           out  1        high from the cycle after start until done
//  done           out  1        1-cycle pulse at scan end
//  res_valid      out  1        1-cycle pulse per finished tap
//  res_tap        out  TAP_W    tap of current result
//  res_err_cnt    out  CNT_W    mismatches at res_tap
//  best_tap       out  TAP_W    centre of widest zero-error run (valid from done)
//  best_len       out  TAP_W+1  length of that run; 0 = no passing tap
// BEHAVIOUR
//  - Single clock clk; reset asynchronous, active-low (rst_n). Reset forces every output to 0
//    and the FSM to IDLE, including mid-scan; no done is produced for an aborted scan.
//  - dly_in and ref_in each pass through a 2-FF synchroniser; comparison uses synced values.
//  - FSM IDLE -> SETTLE -> MEASURE -> REPORT -> (SETTLE | FIN) -> IDLE.
//  - IDLE: start=1 -> next cycle busy=1, delay_line_rx=0, best_tap/best_len/run trackers
//    cleared, enter SETTLE. start is ignored in every other state.
//  - SETTLE: exactly SETTLE_CYC cycles; error counter cleared.
//  - MEASURE: WINDOW_CYC cycles; counter +1 on each cycle where synced dly != synced ref.
//    Saturates at 2**CNT_W-1 and never wraps.
//  - REPORT: 1 cycle; res_valid=1, res_tap=delay_line_rx, res_err_cnt=count. These hold until
//    the next REPORT. Run tracking happens here:
//    - err==0: if cur_len==0 then cur_start=tap; cur_len++.
//    - if the new cur_len > best_len (strict, so the first run wins ties), best_start and
//      best_len take the current run.
//    - err!=0: cur_len=0.
//    - Then: if tap==NUM_TAPS-1 go to FIN, else tap+1 and go to SETTLE.
//  - FIN: 1 cycle; done=1, busy=0.
//    - best_tap = best_start + ((best_len-1)>>1); if best_len==0 then best_tap=0.
//    - best_* hold until the next start.
//  - Tap period is SETTLE_CYC+WINDOW_CYC+1 cycles. done occurs NUM_TAPS*period+1 cycles after
//    the start-sampling edge.
//  - delay_line_rx changes only on REPORT->SETTLE transitions. It is never changed during
//    MEASURE.
// CONFIGURATION
//  DLY_SCAN_EARLY_EXIT_EN
//  - defined: MEASURE exits to REPORT in the cycle after the first mismatch is counted, so
//    res_err_cnt is 0 or 1 and failing taps are shortened.
//  - undefined: MEASURE always runs the full WINDOW_CYC and counts every mismatch.
//  - Run tracking is identical in both builds.
// TESTING (NUM_TAPS=16, SETTLE_CYC=4, WINDOW_CYC=8, CNT_W=16, period=13)
//  1. Assert rst_n=0 -> every output 0. Release with start=0 -> idle, busy=0.
//  2. ref_in=dly_in for all taps; start pulse at cycle 0 -> 16 res_valid with err=0, taps 0..15
//     in order; done at cycle 209; best_len=16, best_tap=7.
//  3. Bench drives dly_in=~ref_in on taps 0-3 and 12-15, equal on taps 4-11 -> failing taps
//     report err=8; best_len=8, best_tap=7.
//  4. Passing runs on taps 2-4 and 9-11 only -> best_len=3, best_tap=3 (first run wins tie).
//     A start pulse while busy is ignored.
//  5. rst_n low during tap 5 MEASURE -> outputs 0 asynchronously, no done. A new start then
//     restarts at tap 0 and the full scan completes.
//  6. DLY_SCAN_EARLY_EXIT_EN defined, constant mismatch -> every tap err=1, period 6;
//     done at cycle 97; best_len=0, best_tap=0.

Source files
------------

// File: rtl/delay_tap_scanner.sv
// delay_tap_scanner: sweeps delay taps, counts per-tap mismatches, reports centre of widest clean run; DLY_SCAN_EARLY_EXIT_EN ends a tap at its first mismatch
module delay_tap_scanner #(
  parameter int TAP_W      = 8,
  parameter int NUM_TAPS   = 256,
  parameter int SETTLE_CYC = 16,
  parameter int WINDOW_CYC = 1024,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dly_in,
  input  logic             ref_in,
  output logic [TAP_W-1:0] delay_line_rx,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  output logic [TAP_W-1:0] res_tap,
  output logic [CNT_W-1:0] res_err_cnt,
  output logic [TAP_W-1:0] best_tap,
  output logic [TAP_W:0]   best_len
);
  localparam int PH_MAX = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, REPORT, FIN} state_t;
  state_t            state, state_n;
  logic [1:0]        dly_sync, ref_sync;
  logic [PH_W-1:0]   ph;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [TAP_W:0]    cur_len, cur_len_n, best_len_n;
  logic [TAP_W-1:0]  cur_start, cur_start_n, best_start, best_start_n, best_tap_n;
  logic              mis, early, ph_end, last_tap, clean, take;
  assign mis = dly_sync[1] ^ ref_sync[1];
`ifdef DLY_SCAN_EARLY_EXIT_EN
  assign early = mis;
`else
  assign early = 1'b0;
`endif
  assign ph_end       = (state == SETTLE) ? (ph == PH_W'(SETTLE_CYC - 1)) : (ph == PH_W'(WINDOW_CYC - 1));
  assign last_tap     = delay_line_rx == TAP_W'(NUM_TAPS - 1);
  assign cnt_n        = (mis && !(&cnt)) ? cnt + 1'b1 : cnt;
  assign clean        = cnt == '0;
  assign cur_len_n    = clean ? cur_len + 1'b1 : '0;
  assign cur_start_n  = (clean && cur_len == '0) ? delay_line_rx : cur_start;
  assign take         = cur_len_n > best_len;
  assign best_len_n   = take ? cur_len_n : best_len;
  assign best_start_n = take ? cur_start_n : best_start;
  assign best_tap_n   = (best_len_n == '0) ? '0 : best_start_n + TAP_W'((best_len_n - 1'b1) >> 1);
  assign busy         = state inside {SETTLE, MEASURE, REPORT};
  assign done         = state == FIN;
  assign res_valid    = state == REPORT;
  // two-stage synchronisers for the asynchronous sample inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_sync <= '0;
      ref_sync <= '0;
    end else begin
      dly_sync <= {dly_sync[0], dly_in};
      ref_sync <= {ref_sync[0], ref_in};
    end
  end
  // sweep sequencing: start is only honoured in IDLE
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? SETTLE : IDLE;
      SETTLE:  state_n = ph_end ? MEASURE : SETTLE;
      MEASURE: state_n = (ph_end || early) ? REPORT : MEASURE;
      REPORT:  state_n = last_tap ? FIN : SETTLE;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state register and per-phase cycle counter, restarted on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ph    <= '0;
    end else begin
      state <= state_n;
      ph    <= (state_n != state) ? '0 : ph + 1'b1;
    end
  end
  // saturating mismatch counter, cleared while the tap settles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (state == SETTLE) cnt <= '0;
    else if (state == MEASURE) cnt <= cnt_n;
  end
  // tap stepping, result capture and widest-clean-run tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_line_rx <= '0;
      res_tap       <= '0;
      res_err_cnt   <= '0;
      cur_len       <= '0;
      cur_start     <= '0;
      best_len      <= '0;
      best_start    <= '0;
      best_tap      <= '0;
    end else begin
      if (state == IDLE && start) begin
        delay_line_rx <= '0;
        cur_len       <= '0;
        cur_start     <= '0;
        best_len      <= '0;
        best_start    <= '0;
        best_tap      <= '0;
      end
      if (state == MEASURE && state_n == REPORT) begin
        res_tap     <= delay_line_rx;
        res_err_cnt <= cnt_n;
      end
      if (state == REPORT) begin
        cur_len    <= cur_len_n;
        cur_start  <= cur_start_n;
        best_len   <= best_len_n;
        best_start <= best_start_n;
        if (last_tap) best_tap <= best_tap_n;
        else delay_line_rx <= delay_line_rx + 1'b1;
      end
    end
  end
endmodule
